latch_wr_sched: RTL and testbench



---
 rtl/latch_sched_pkg.sv | 23 ++
 rtl/latch_wr_sched_arbiter.sv | 31 +++
 rtl/latch_wr_sched.sv | 166 ++++++++++++++++
 tb/tb_latch_wr_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_sched_pkg.sv
// Shared types and helpers for the latch write scheduler.
// Holds the FSM state encoding, the latch data width and the counter sizing function.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int LAT_DW = 8;

  // The counter only ever holds (phase length - 1), so size it for the longest phase minus one.
  function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/latch_wr_sched_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr_i, wrapping.
// The pointer register lives in the instantiating module.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/latch_wr_sched.sv
// Shares one latch data bus among N_REQ requesters: round-robin grant, then setup / enable pulse / hold,
// then a one-cycle ack (with err for out-of-range addresses). All outputs are registered.
module latch_wr_sched
  import latch_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int NUM_LAT   = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LAT_DW-1:0]  req_data,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]         ack,
  output logic                     err,
  output logic [LAT_DW-1:0]        lat_d,
  output logic [NUM_LAT-1:0]       lat_en,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [ADDR_W:0] NUM_LAT_X = (ADDR_W + 1)'(NUM_LAT);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [LAT_DW-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bad_q, bad_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_LAT-1:0]  lat_en_q, lat_en_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    elig;
  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic [LAT_DW-1:0]   sel_data;
  logic [ADDR_W-1:0]   sel_addr;

  // The requester being acked this cycle is still holding req high; keep it out of the next grant.
  assign elig = req & ~ack_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_data = req_data[i*LAT_DW +: LAT_DW];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    addr_d   = addr_q;
    bad_d    = bad_q;
    gnt_d    = gnt_q;
    lat_en_d = '0;
    ack_d    = '0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          data_d  = sel_data;
          addr_d  = sel_addr;
          bad_d   = ({1'b0, sel_addr} >= NUM_LAT_X);
          gnt_d   = arb_gnt;
          ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = OPEN;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ack_d   = gnt_q;
          err_d   = bad_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An out-of-range address drops the write entirely rather than decoding a partial enable.
    if (state_d == OPEN && !bad_d) begin
      for (int i = 0; i < NUM_LAT; i++) begin
        lat_en_d[i] = (addr_d == ADDR_W'(i));
      end
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      bad_q    <= 1'b0;
      gnt_q    <= '0;
      lat_en_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      bad_q    <= bad_d;
      gnt_q    <= gnt_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign lat_d  = data_q;
  assign lat_en = lat_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched with NUM_LAT=3 so that address 3 is out of range.
// Expected writes are queued when a request is raised and checked by a monitor on each ack.
module tb_latch_wr_sched;

  localparam int N  = 4;
  localparam int NL = 3;
  localparam int AW = 2;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    logic [7:0] data;
    logic [2:0] mask;
    int         cycles;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [1:0] addr;
    logic [3:0] expAck;
    logic       expErr;
    logic [2:0] expMask;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*8-1:0]  reqData;
  logic [N*AW-1:0] reqAddr;
  logic [N-1:0]  ack;
  logic          err;
  logic [7:0]    latD;
  logic [NL-1:0] latEn;
  logic          busy;

  exp_t scoreQ[$];
  int   total = 0;
  int   bad   = 0;

  latch_wr_sched #(
    .N_REQ(N), .NUM_LAT(NL), .ADDR_W(AW),
    .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (reqData),
    .req_addr (reqAddr),
    .ack      (ack),
    .err      (err),
    .lat_d    (latD),
    .lat_en   (latEn),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] d, input logic [1:0] a);
    reqData[idx*8 +: 8]   = d;
    reqAddr[idx*AW +: AW] = a;
    req[idx]              = 1'b1;
  endtask

  task automatic pushExp(input logic [3:0] a, input logic e, input logic [7:0] d, input logic [2:0] m);
    exp_t x;
    x.ack    = a;
    x.err    = e;
    x.data   = d;
    x.mask   = m;
    x.cycles = (m != 0) ? 2 : 0;
    scoreQ.push_back(x);
  endtask

  task automatic waitAck(input int idx, output int n);
    n = 0;
    while (!ack[idx] && n < 30) begin
      step();
      n++;
    end
    if (!ack[idx]) checkOutput("ack_timeout", 0, 1);
  endtask

  // Monitor: accumulates the enable pulse of the current write and scores it when the ack arrives.
  initial begin
    logic [2:0] enMask;
    logic [7:0] enData;
    logic [7:0] prevD;
    int         enCycles;
    exp_t       e;
    enMask   = '0;
    enData   = '0;
    prevD    = '0;
    enCycles = 0;
    forever begin
      step();
      if (latEn != 0) begin
        checkOutput("en_onehot", 32'($onehot(latEn)), 1);
        checkOutput("d_stable_at_en", latD, prevD);
        enMask |= latEn;
        enCycles++;
        enData = latD;
      end
      if (err && ack == 0) checkOutput("err_without_ack", err, 0);
      if (ack != 0) begin
        if (scoreQ.size() == 0) begin
          checkOutput("unexpected_ack", ack, 0);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("ack", ack, e.ack);
          checkOutput("err", err, e.err);
          checkOutput("ack_lat_d", latD, e.data);
          checkOutput("en_mask", enMask, e.mask);
          checkOutput("en_cycles", enCycles, e.cycles);
          if (e.mask != 0) checkOutput("en_data", enData, e.data);
        end
      end
      if (!busy) begin
        enMask   = '0;
        enCycles = 0;
      end
      prevD = latD;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{0, 8'h3C, 2'd0, 4'b0001, 1'b0, 3'b001};
    vecs[1] = '{2, 8'h00, 2'd1, 4'b0100, 1'b0, 3'b010};
    vecs[2] = '{3, 8'hFF, 2'd3, 4'b1000, 1'b1, 3'b000};
    vecs[3] = '{1, 8'h81, 2'd2, 4'b0010, 1'b0, 3'b100};
    vecs[4] = '{3, 8'h7E, 2'd0, 4'b1000, 1'b0, 3'b001};
    vecs[5] = '{2, 8'hFF, 2'd3, 4'b0100, 1'b1, 3'b000};

    rst = 1'b1; req = '0; reqData = '0; reqAddr = '0;
    repeat (3) step();
    checkOutput("rst_lat_en", latEn, 0);
    checkOutput("rst_lat_d", latD, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Single write with exact cycle-by-cycle timing.
    applyStimulus(1, 8'hA5, 2'd2);
    pushExp(4'b0010, 1'b0, 8'hA5, 3'b100);
    step();
    checkOutput("t1_lat_d", latD, 8'hA5);
    checkOutput("t1_en", latEn, 0);
    checkOutput("t1_busy", busy, 1);
    step();
    checkOutput("t2_en", latEn, 3'b100);
    checkOutput("t2_busy", busy, 1);
    step();
    checkOutput("t3_en", latEn, 3'b100);
    step();
    checkOutput("t4_en", latEn, 0);
    checkOutput("t4_busy", busy, 1);
    checkOutput("t4_lat_d", latD, 8'hA5);
    step();
    checkOutput("t5_ack", ack, 4'b0010);
    checkOutput("t5_busy", busy, 0);
    req[1] = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].data, vecs[i].addr);
      pushExp(vecs[i].expAck, vecs[i].expErr, vecs[i].data, vecs[i].expMask);
      waitAck(vecs[i].idx, n);
      checkOutput("tbl_latency", n, 5);
      req[vecs[i].idx] = 1'b0;
      step();
    end

    // All four at once from pointer 0 (addr 3 is out of range here).
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 8'(8'h11 * (i + 1)), 2'(i));
      pushExp(4'(1 << i), (i == 3), 8'(8'h11 * (i + 1)), (i == 3) ? 3'b000 : 3'(1 << i));
    end
    for (int k = 0; k < 4; k++) begin
      waitAck(k, n);
      checkOutput("rr4_latency", n, 5);
      req[k] = 1'b0;
    end
    step();

    // Move the pointer to 3, then keep req[0] and req[3] asserted.
    applyStimulus(2, 8'h42, 2'd1);
    pushExp(4'b0100, 1'b0, 8'h42, 3'b010);
    waitAck(2, n);
    checkOutput("fair_pre_latency", n, 5);
    req[2] = 1'b0;
    step();
    applyStimulus(0, 8'h10, 2'd1);
    applyStimulus(3, 8'h30, 2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) pushExp(4'b1000, 1'b0, 8'h30, 3'b001);
      else            pushExp(4'b0001, 1'b0, 8'h10, 3'b010);
    end
    for (int k = 0; k < 4; k++) begin
      waitAck((k % 2 == 0) ? 3 : 0, n);
      checkOutput("fair_latency", n, 5);
    end
    req[0] = 1'b0;
    req[3] = 1'b0;
    step();

    // Reset in the middle of the enable pulse; pointer must restart at 0.
    applyStimulus(2, 8'h99, 2'd1);
    step();
    checkOutput("rst_mid_setup_d", latD, 8'h99);
    step();
    checkOutput("rst_mid_open_en", latEn, 3'b010);
    rst = 1'b1;
    step();
    checkOutput("rst_mid_en", latEn, 0);
    checkOutput("rst_mid_d", latD, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_ack", ack, 0);
    rst = 1'b0;
    applyStimulus(3, 8'h77, 2'd2);
    pushExp(4'b0100, 1'b0, 8'h99, 3'b010);
    pushExp(4'b1000, 1'b0, 8'h77, 3'b100);
    waitAck(2, n);
    checkOutput("rst_mid_latency2", n, 5);
    req[2] = 1'b0;
    waitAck(3, n);
    checkOutput("rst_mid_latency3", n, 5);
    req[3] = 1'b0;
    step();

    // Data changes after grant must not reach the in-flight write.
    applyStimulus(1, 8'h5A, 2'd0);
    pushExp(4'b0010, 1'b0, 8'h5A, 3'b001);
    step();
    checkOutput("chg_setup_d", latD, 8'h5A);
    reqData[8 +: 8] = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("chg_hold_d", latD, 8'h5A);
    end
    waitAck(1, n);
    checkOutput("chg_latency", n, 1);
    req[1] = 1'b0;
    step();
    applyStimulus(1, 8'hC3, 2'd0);
    pushExp(4'b0010, 1'b0, 8'hC3, 3'b001);
    waitAck(1, n);
    checkOutput("chg_next_latency", n, 5);
    req[1] = 1'b0;

    repeat (4) step();
    checkOutput("queue_empty", scoreQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
